bc55_bus_ctrl: RTL
==================

# bc55_bus_ctrl

Bus controller answering the CPU's data-side bus (`cpu_bc_addr`, `cpu_bc_data`, `cpu_bc_rw` → `bc_cpu_data`). Sits between the CPU's memory stage and the data-memory subsystem. It decodes each request into one of three regions:

- a local word RAM;
- a slow external port with fixed wait states;
- a small CSR bank.

Each request is answered with a single-cycle `bc_cpu_ready` pulse, which also stalls the pipeline while an access is pending.

## Interface
- `RAM_AW`, 10, word-address width of local RAM (2^RAM_AW × 32-bit words)
- `EXT_WAIT`, 3, wait cycles for external region (≥1)
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset: synchronous and active-high
- `cpu_bc_req`  in  1  request valid; held with addr/data/rw until ready
- `cpu_bc_addr`  in  32  byte address; bits [1:0] ignored
- `cpu_bc_data`  in  32  write data
- `cpu_bc_rw`  in  1  1 = write, 0 = read
- `bc_cpu_data`  out  32  read data, valid only in ready cycle
- `bc_cpu_ready`  out  1  one-cycle completion pulse
- `ext_addr`  out  32  external address (registered copy of `cpu_bc_addr`)
- `ext_wdata`  out  32  external write data
- `ext_we` / `ext_re`  out  1  external strobes, held high for the entire wait phase
- `ext_rdata`  in  32  external read data, sampled on last wait cycle

## Operation
- Decode on `addr[31:28]`:
  - 0x0 → RAM, word index `addr[RAM_AW+1:2]`; upper bits ignored, so the RAM aliases.
  - 0x8 → EXT.
  - 0xF → CSR.
  - Anything else → unmapped.
- FSM states: IDLE, RAM, EXT_WAIT, CSR, ERR, DONE.
- IDLE: on `cpu_bc_req` register addr, data and rw, then go to the state for the decoded region. A RAM write commits at this accepting edge.
- RAM: ready=1; data = RAM word (synchronous read); go to DONE.
- EXT_WAIT:
  - Strobes are asserted and a wait counter loads `EXT_WAIT-1` on entry.
  - The counter decrements each cycle. At 0, capture `ext_rdata` and go to DONE with ready=1 the following cycle.
- CSR:
  - Offset `addr[3:2]`: 0 = ID (read-only, `BC55_ID` = 0x0055_0001); 1 = scratch (R/W); 2 = status; 3 = cycle counter (read-only).
  - Status bit0 is the sticky unmapped-error flag, write-1-to-clear; the other status bits read 0.
  - Writes to read-only registers are dropped.
  - ready=1 with data; go to DONE.
- ERR:
  - Read returns 0xDEAD_BEEF; a write is discarded.
  - Sets the sticky error flag; ready=1; go to DONE.
- DONE: ready=0. Always returns to IDLE, so every request takes at least 2 cycles from request to the next acceptance.
- If a W1C write and a new unmapped access coincide, the set wins.

## Timing
- Request accepted at edge t:
  - RAM, CSR, unmapped: ready high in cycle t+1.
  - EXT: ready high in cycle t+1+EXT_WAIT.
- `ext_we`/`ext_re` are high for exactly EXT_WAIT cycles, starting at t+1.
- The next request is accepted no earlier than edge t+2 for RAM/CSR/unmapped.
- `bc_cpu_data` holds its last value outside the ready cycle. The CPU must not sample it then.
- Reset values: `bc_cpu_ready`=0, `bc_cpu_data`=0, `ext_we`=`ext_re`=0, `ext_addr`=`ext_wdata`=0, FSM=IDLE, scratch=0, error flag=0, counter=0. RAM contents are not reset.
- Reset mid-access aborts the access immediately. No ready is issued, and strobes drop on the next edge.
- Changing `cpu_bc_req`/addr while pending is a protocol violation. The registered copy is used.

## Configuration
- `BC55_CYCLE_CNT_EN` defined: CSR offset 3 is a free-running 32-bit counter. It increments every cycle from reset and wraps from 0xFFFF_FFFF to 0.
- Not defined: offset 3 reads 0 and no counter flops exist.

## Structure
- Package `bc55_pkg`: region codes, FSM state enum, CSR offset constants, `BC55_ID`, `BC55_ERR_DATA` (0xDEAD_BEEF).
- Sub-module `bc55_ram`: single-port synchronous RAM (depth 2^RAM_AW, write-enable, 1-cycle read). The FSM and CSRs stay in `bc55_bus_ctrl`.

## Test plan
- Write 0x1234_5678 to 0x0000_0010, then read 0x0000_0010 → ready one cycle after each acceptance; read data 0x1234_5678. A read of 0x0000_1010 (alias, RAM_AW=10) returns the same value.
- Read 0x8000_0004 with EXT_WAIT=3, `ext_rdata`=0xCAFE_0001 → `ext_re` high 3 cycles, `ext_addr`=0x8000_0004, ready at t+4 with 0xCAFE_0001.
- Read 0xF000_0000 → 0x0055_0001. Write 0xA5A5_A5A5 to 0xF000_0004, read back → 0xA5A5_A5A5. A write to 0xF000_0000 leaves the ID unchanged.
- Read 0x4000_0000 → 0xDEAD_BEEF and status=1. Write 1 to 0xF000_0008 → status reads 0.
- Assert `rst` during the second EXT wait cycle → no ready pulse, strobes 0 next cycle, scratch=0. A subsequent RAM read completes normally.
- With `BC55_CYCLE_CNT_EN`: two reads of 0xF000_000C accepted N cycles apart differ by N. Without the macro both read 0.

Source files
------------

// File: rtl/bc55_pkg.sv
// Shared definitions for the bc55 data-side bus controller: region decode,
// FSM states, CSR map and fixed response words.
package bc55_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] REG_RAM = 4'h0;
  localparam logic [3:0] REG_EXT = 4'h8;
  localparam logic [3:0] REG_CSR = 4'hF;

  localparam logic [1:0] CSR_ID      = 2'd0;
  localparam logic [1:0] CSR_SCRATCH = 2'd1;
  localparam logic [1:0] CSR_STATUS  = 2'd2;
  localparam logic [1:0] CSR_CYCLE   = 2'd3;

  localparam logic [31:0] BC55_ID       = 32'h0055_0001;
  localparam logic [31:0] BC55_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_EXT,
    RGN_CSR,
    RGN_ERR
  } region_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAM,
    ST_EXT_WAIT,
    ST_CSR,
    ST_ERR,
    ST_DONE
  } state_e;

  function automatic region_e decode(input logic [31:0] addr);
    case (addr[31:28])
      REG_RAM: return RGN_RAM;
      REG_EXT: return RGN_EXT;
      REG_CSR: return RGN_CSR;
      default: return RGN_ERR;
    endcase
  endfunction

endpackage

// File: rtl/bc55_ram.sv
// Single-port synchronous word RAM with one-cycle registered read.
module bc55_ram
  import bc55_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  // NOTE: the array has no reset so it maps onto a RAM macro; only control state is reset.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so order is irrelevant.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bc55_bus_ctrl.sv
// Data-side bus controller: decodes CPU requests to local RAM, a wait-stated
// external port or a CSR bank. Define BC55_CYCLE_CNT_EN to add the cycle counter CSR.
module bc55_bus_ctrl
  import bc55_pkg::*;
#(
  parameter int RAM_AW   = 10,
  parameter int EXT_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_bc_req,
  input  logic [31:0] cpu_bc_addr,
  input  logic [31:0] cpu_bc_data,
  input  logic        cpu_bc_rw,
  output logic [31:0] bc_cpu_data,
  output logic        bc_cpu_ready,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  output logic        ext_we,
  output logic        ext_re,
  input  logic [31:0] ext_rdata
);

  localparam int CNT_W = (EXT_WAIT > 1) ? $clog2(EXT_WAIT) : 1;

  state_e            state, state_nxt;
  logic [31:0]       addr_q, wdata_q, ext_rdata_q, data_hold_q, scratch_q;
  logic              rw_q, err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       ram_rdata, csr_rdata, cycle_val, resp;
  logic              ready, ext_strobe, ram_we, csr_we, err_set;
  logic              accept;

  assign accept = (state == ST_IDLE) && cpu_bc_req;

  // RAM writes commit on the accepting edge, straight from the request bus.
  bc55_ram #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (cpu_bc_addr[RAM_AW+1:2]),
    .wdata (cpu_bc_data),
    .rdata (ram_rdata)
  );

`ifdef BC55_CYCLE_CNT_EN
  logic [31:0] cycle_q;
  always_ff @(posedge clk) begin
    if (rst) cycle_q <= '0;
    else     cycle_q <= cycle_q + 32'd1;
  end
  assign cycle_val = cycle_q;
`else
  assign cycle_val = '0;
`endif

  always_comb begin
    case (addr_q[3:2])
      CSR_ID:      csr_rdata = BC55_ID;
      CSR_SCRATCH: csr_rdata = scratch_q;
      CSR_STATUS:  csr_rdata = {31'd0, err_q};
      default:     csr_rdata = cycle_val;
    endcase
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    resp       = data_hold_q;
    ext_strobe = 1'b0;
    ram_we     = 1'b0;
    csr_we     = 1'b0;
    err_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_bc_req) begin
          case (decode(cpu_bc_addr))
            RGN_RAM: begin
              ram_we    = cpu_bc_rw;
              state_nxt = ST_RAM;
            end
            RGN_EXT: state_nxt = ST_EXT_WAIT;
            RGN_CSR: state_nxt = ST_CSR;
            default: state_nxt = ST_ERR;
          endcase
        end
      end
      ST_RAM: begin
        ready     = 1'b1;
        resp      = ram_rdata;
        state_nxt = ST_DONE;
      end
      ST_EXT_WAIT: begin
        ext_strobe = 1'b1;
        if (cnt_q == '0) state_nxt = ST_DONE;
      end
      ST_CSR: begin
        ready     = 1'b1;
        resp      = csr_rdata;
        csr_we    = rw_q;
        state_nxt = ST_DONE;
      end
      ST_ERR: begin
        ready     = 1'b1;
        resp      = BC55_ERR_DATA;
        err_set   = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // The external path completes here, one cycle after its last wait cycle.
        if (decode(addr_q) == RGN_EXT) begin
          ready = 1'b1;
          resp  = ext_rdata_q;
        end
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rw_q        <= 1'b0;
      cnt_q       <= '0;
      ext_rdata_q <= '0;
      data_hold_q <= '0;
      scratch_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= cpu_bc_addr;
        wdata_q <= cpu_bc_data;
        rw_q    <= cpu_bc_rw;
        cnt_q   <= CNT_W'(EXT_WAIT - 1);
      end else if (state == ST_EXT_WAIT) begin
        if (cnt_q == '0) ext_rdata_q <= ext_rdata;
        else             cnt_q       <= cnt_q - 1'b1;
      end
      if (ready) data_hold_q <= resp;
      if (csr_we && addr_q[3:2] == CSR_SCRATCH) scratch_q <= wdata_q;
      // A new unmapped access beats a coincident write-1-to-clear.
      if (err_set)
        err_q <= 1'b1;
      else if (csr_we && addr_q[3:2] == CSR_STATUS && wdata_q[0])
        err_q <= 1'b0;
    end
  end

  assign bc_cpu_ready = ready;
  assign bc_cpu_data  = resp;
  assign ext_addr     = addr_q;
  assign ext_wdata    = wdata_q;
  assign ext_we       = ext_strobe & rw_q;
  assign ext_re       = ext_strobe & ~rw_q;

endmodule
